// File: rtl/serial_shifter_32_bit.sv
// serial_shifter_32_bit: multi-cycle 32-bit shift/rotate, one bit position per clock, start/done handshake
module serial_shifter_32_bit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic [31:0] data_a,
  input  logic [4:0]  shift_amount,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]  state;
  logic [31:0] w;
  logic [31:0] step;
  logic [4:0]  c;
  logic [2:0]  m;
  logic        accept;
  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = state == SHIFT;
  assign done   = state == DONE;
  always_comb begin
    step = m == 3'd0 ? {w[30:0], 1'b0} :
           m == 3'd1 ? {w[30:0], w[31]} :
           m == 3'd2 ? {1'b0, w[31:1]} :
           m == 3'd3 ? {w[31], w[31:1]} :
           m == 3'd4 ? {w[0], w[31:1]} : w;
  end
  // pass-through modes load a zero count so they finish with the minimum latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      w      <= '0;
      c      <= '0;
      m      <= '0;
      result <= '0;
    end else if (accept) begin
      state <= SHIFT;
      w     <= data_a;
      c     <= mode > 3'd4 ? 5'd0 : shift_amount;
      m     <= mode;
    end else if (state == SHIFT) begin
      if (c != 5'd0) begin
        w <= step;
        c <= c - 5'd1;
      end else begin
        result <= w;
        state  <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_shifter_32_bit.sv
// tb_serial_shifter_32_bit: scenario tasks with a result scoreboard for serial_shifter_32_bit
module tb_serial_shifter_32_bit;
  logic        clock = 0;
  logic        reset_n = 0;
  logic        start = 0;
  logic [2:0]  mode = 0;
  logic [31:0] data_a = 0;
  logic [4:0]  shift_amount = 0;
  logic        busy, done;
  logic [31:0] result;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] q[$];
  logic [31:0] exp_v;

  serial_shifter_32_bit dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .data_a(data_a),
    .shift_amount(shift_amount), .busy(busy), .done(done), .result(result)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [2:0] mm, input logic [31:0] a, input logic [4:0] n);
    case (mm)
      3'd0: model = a << n;
      3'd1: model = n == 0 ? a : (a << n) | (a >> (32 - n));
      3'd2: model = a >> n;
      3'd3: model = $signed(a) >>> n;
      3'd4: model = n == 0 ? a : (a >> n) | (a << (32 - n));
      default: model = a;
    endcase
  endfunction

  // latency counts edges from the capture edge (inclusive) to the edge that raises done
  task automatic run_op(input string name, input logic [2:0] mm, input logic [31:0] a,
                        input logic [4:0] n, input logic [31:0] expv, input int exp_lat);
    int lat;
    start = 1; mode = mm; data_a = a; shift_amount = n;
    q.push_back(expv);
    tick();
    lat = 1;
    start = 0; data_a = $urandom; shift_amount = 5'($urandom); mode = 3'($urandom);
    if (busy !== 1'b1) begin mismatched++; $display("FAIL %s busy_after_capture got %b want 1", name, busy); end
    compared++;
    while (!done && lat < 40) begin tick(); lat++; end
    exp_v = q.pop_front();
    if (lat !== exp_lat) begin mismatched++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
    compared++;
    if (result !== exp_v) begin mismatched++; $display("FAIL %s result got %h want %h", name, result, exp_v); end
    compared++;
    tick();
    if (done !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL %s pulse_end got done=%b busy=%b want 0/0", name, done, busy); end
    compared++;
  endtask

  task automatic test_reset();
    int dones;
    #2;
    if ({busy, done, result} !== 33'h0) begin mismatched++; $display("FAIL reset_initial got busy=%b done=%b result=%h want 0", busy, done, result); end
    compared++;
    tick(); reset_n = 1; tick();
    start = 1; mode = 0; data_a = 32'h1; shift_amount = 5'd20;
    tick(); start = 0;
    repeat (5) tick();
    reset_n = 0;
    #1;
    if ({busy, done, result} !== 33'h0) begin mismatched++; $display("FAIL reset_mid got busy=%b done=%b result=%h want 0", busy, done, result); end
    compared++;
    tick(); reset_n = 1;
    dones = 0;
    repeat (30) begin tick(); if (done) dones++; end
    if (dones !== 0 || result !== 32'h0) begin mismatched++; $display("FAIL reset_no_done got dones=%0d result=%h want 0/0", dones, result); end
    compared++;
  endtask

  task automatic test_modes();
    run_op("mode0", 3'd0, 32'h8000_0001, 5'd4, 32'h0000_0010, 6);
    run_op("mode1", 3'd1, 32'h8000_0001, 5'd4, 32'h0000_0018, 6);
    run_op("mode2", 3'd2, 32'h8000_0001, 5'd4, 32'h0800_0000, 6);
    run_op("mode3", 3'd3, 32'h8000_0001, 5'd4, 32'hF800_0000, 6);
    run_op("mode4", 3'd4, 32'h8000_0001, 5'd4, 32'h1800_0000, 6);
    run_op("mode6", 3'd6, 32'h8000_0001, 5'd4, 32'h8000_0001, 2);
  endtask

  task automatic test_boundary();
    run_op("sra31", 3'd3, 32'hF000_0000, 5'd31, 32'hFFFF_FFFF, 33);
    run_op("ror0", 3'd4, 32'h1234_5678, 5'd0, 32'h1234_5678, 2);
    run_op("sll31", 3'd0, 32'h0000_0003, 5'd31, 32'h8000_0000, 33);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  mm;
      logic [31:0] a;
      logic [4:0]  n;
      mm = 3'($urandom_range(0, 7)); a = $urandom; n = 5'($urandom);
      run_op("random", mm, a, n, model(mm, a, n), mm > 3'd4 ? 2 : int'(n) + 2);
    end
  endtask

  task automatic test_start_ignored();
    int lat, dones;
    start = 1; mode = 3'd2; data_a = 32'hFFFF_FFFF; shift_amount = 5'd8;
    q.push_back(32'h00FF_FFFF);
    tick(); lat = 1; start = 0;
    repeat (3) begin tick(); lat++; end
    start = 1; mode = 3'd0; data_a = 32'h0000_0001; shift_amount = 5'd2;
    tick(); lat++; start = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    exp_v = q.pop_front();
    if (result !== exp_v || lat !== 10) begin mismatched++; $display("FAIL ignored_result got %h lat=%0d want %h lat=10", result, lat, exp_v); end
    compared++;
    dones = 0;
    repeat (20) begin tick(); if (done) dones++; end
    if (dones !== 0) begin mismatched++; $display("FAIL ignored_second_done got %0d want 0", dones); end
    compared++;
  endtask

  task automatic test_back_to_back();
    int lat, holds;
    start = 1; mode = 3'd0; data_a = 32'h1; shift_amount = 5'd1;
    q.push_back(32'h2);
    tick(); lat = 1;
    while (!done && lat < 40) begin tick(); lat++; end
    exp_v = q.pop_front();
    if (result !== exp_v || lat !== 3) begin mismatched++; $display("FAIL b2b_a got %h lat=%0d want %h lat=3", result, lat, exp_v); end
    compared++;
    mode = 3'd2; data_a = 32'h100; shift_amount = 5'd8;
    q.push_back(32'h1);
    tick(); lat = 1; start = 0;
    if (done !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL b2b_capture got done=%b busy=%b want 0/1", done, busy); end
    compared++;
    holds = 0;
    while (!done && lat < 40) begin
      if (result !== 32'h2) holds++;
      tick(); lat++;
    end
    if (holds !== 0) begin mismatched++; $display("FAIL b2b_hold got %0d bad cycles want 0", holds); end
    compared++;
    exp_v = q.pop_front();
    if (result !== exp_v || lat !== 10) begin mismatched++; $display("FAIL b2b_b got %h lat=%0d want %h lat=10", result, lat, exp_v); end
    compared++;
    tick();
  endtask

  initial begin
    test_reset();
    test_modes();
    test_boundary();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
